// File: rtl/ram8_arbiter.sv
// ram8_arbiter
// Two-port round-robin arbiter in front of one shared 8-word memory
// (combinational read, write on the rising clock edge), plus a sequencer
// that clears the whole memory.
//
// Ports
//   clk, rst             single clock; synchronous active-high reset
//   clr_req / clr_busy   clear request; high while the clear sequence runs
//   a_* / b_*            per-port access channel:
//                          req, we, addr, wdata   request side
//                          gnt                    one-cycle pulse when the access is issued
//                          rvalid, rdata          read result, one cycle after gnt
//   mem_load, mem_addr,  strobe, address and write data to the shared memory
//   mem_wdata
//   mem_rdata            combinational read data from the shared memory
//   dbg_state            current FSM state (0 IDLE, 1 SERVE, 2 CLEAR)
//
// Handshake: a requester raises x_req together with x_we/x_addr/x_wdata and
// holds all of them stable until it sees x_gnt high; the access is issued in
// the gnt cycle. A read returns x_rvalid (one-cycle pulse) with x_rdata in the
// following cycle. x_rdata holds its value until the next read on that port
// completes. There is no backpressure on rvalid.
module ram8_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              clr_busy,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_load,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t state, state_nxt;

    // 1 = port B was served last, so A wins the next tie.
    logic              last_b;
    logic              pick_b;

    // Command register: the winning request, captured in IDLE.
    logic              cmd_b;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic [ADDR_W-1:0] clr_cnt;

    // Last values driven onto the memory bus, replayed while IDLE.
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              serve_rd_a;
    logic              serve_rd_b;
    logic              capture;

    assign dbg_state = state;

    // A single requester always wins; on a tie the port not served last wins.
    assign pick_b     = b_req && (!a_req || !last_b);
    assign capture    = (state == IDLE) && (state_nxt == SERVE);
    assign serve_rd_a = (state == SERVE) && !cmd_we && !cmd_b;
    assign serve_rd_b = (state == SERVE) && !cmd_we && cmd_b;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                end else if (a_req || b_req) begin
                    state_nxt = SERVE;
                end
            end
            SERVE: state_nxt = IDLE;
            CLEAR: begin
                if (clr_cnt == {ADDR_W{1'b1}}) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        a_gnt     = 1'b0;
        b_gnt     = 1'b0;
        clr_busy  = 1'b0;
        mem_load  = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        case (state)
            SERVE: begin
                a_gnt     = !cmd_b;
                b_gnt     = cmd_b;
                mem_load  = cmd_we;
                mem_addr  = cmd_addr;
                mem_wdata = cmd_wdata;
            end
            CLEAR: begin
                clr_busy  = 1'b1;
                mem_load  = 1'b1;
                mem_addr  = clr_cnt;
                mem_wdata = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_b    <= 1'b1;
            cmd_b     <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            clr_cnt   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            a_rvalid  <= 1'b0;
            b_rvalid  <= 1'b0;
            a_rdata   <= '0;
            b_rdata   <= '0;
        end else begin
            state    <= state_nxt;
            addr_q   <= mem_addr;
            wdata_q  <= mem_wdata;
            a_rvalid <= serve_rd_a;
            b_rvalid <= serve_rd_b;
            if (serve_rd_a) begin
                a_rdata <= mem_rdata;
            end
            if (serve_rd_b) begin
                b_rdata <= mem_rdata;
            end
            if (capture) begin
                cmd_b     <= pick_b;
                cmd_we    <= pick_b ? b_we    : a_we;
                cmd_addr  <= pick_b ? b_addr  : a_addr;
                cmd_wdata <= pick_b ? b_wdata : a_wdata;
                last_b    <= pick_b;
            end
            clr_cnt <= (state == CLEAR) ? clr_cnt + 1'b1 : '0;
        end
    end

endmodule

// File: tb/tb_ram8_arbiter.sv
// Testbench for ram8_arbiter: directed accesses, round-robin, clear and
// reset-abort scenarios. Expected events go into a queue when stimulus is
// issued; a monitor on the falling edge pops and compares each DUT event.
module tb_ram8_arbiter;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int EV_W   = 3 + 1 + ADDR_W + DATA_W;

    // Event kinds
    localparam logic [2:0] K_AGNT = 3'd0;
    localparam logic [2:0] K_BGNT = 3'd1;
    localparam logic [2:0] K_ARV  = 3'd2;
    localparam logic [2:0] K_BRV  = 3'd3;
    localparam logic [2:0] K_CLR  = 3'd4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clr_req = 1'b0;
    logic              clr_busy;
    logic              a_req = 1'b0, a_we = 1'b0;
    logic [ADDR_W-1:0] a_addr = '0;
    logic [DATA_W-1:0] a_wdata = '0;
    logic              a_gnt, a_rvalid;
    logic [DATA_W-1:0] a_rdata;
    logic              b_req = 1'b0, b_we = 1'b0;
    logic [ADDR_W-1:0] b_addr = '0;
    logic [DATA_W-1:0] b_wdata = '0;
    logic              b_gnt, b_rvalid;
    logic [DATA_W-1:0] b_rdata;
    logic              mem_load;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [1:0]        dbg_state;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    bit prev_gnt = 1'b0;

    logic [EV_W-1:0] exp_q[$];
    logic [DATA_W-1:0] tb_mem [0:7];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- shared memory model ----------------
    assign mem_rdata = tb_mem[mem_addr];
    always @(posedge clk) begin
        if (mem_load) tb_mem[mem_addr] <= mem_wdata;
    end

    ram8_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .clr_req(clr_req), .clr_busy(clr_busy),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_load(mem_load), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    function automatic logic [EV_W-1:0] ev(input logic [2:0] k, input logic ld,
                                           input logic [ADDR_W-1:0] ad,
                                           input logic [DATA_W-1:0] d);
        return {k, ld, ad, d};
    endfunction

    // ---------------- scoreboard / monitor ----------------
    task automatic sb_check(input logic [EV_W-1:0] got, input string name);
        logic [EV_W-1:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected event got=%h (queue empty)", name, got);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL %s: got=%h expected=%h", name, got, exp);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (clr_busy)  sb_check(ev(K_CLR, mem_load, mem_addr, mem_wdata), "clear_cycle");
            if (a_gnt)     sb_check(ev(K_AGNT, mem_load, mem_addr, mem_wdata), "a_gnt");
            if (b_gnt)     sb_check(ev(K_BGNT, mem_load, mem_addr, mem_wdata), "b_gnt");
            if (a_rvalid)  sb_check(ev(K_ARV, 1'b0, '0, a_rdata), "a_rvalid");
            if (b_rvalid)  sb_check(ev(K_BRV, 1'b0, '0, b_rdata), "b_rvalid");
            if (a_gnt || b_gnt) begin
                checks++;
                if ((a_gnt && b_gnt) || prev_gnt) begin
                    errors++;
                    $display("FAIL gnt_spacing: a_gnt=%0b b_gnt=%0b prev_gnt=%0b required single gnt with idle cycle before",
                             a_gnt, b_gnt, prev_gnt);
                end
            end
            prev_gnt = a_gnt || b_gnt;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One access on one port; pushes the expected gnt (and rvalid for reads).
    task automatic op(input bit port_b, input bit we, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] rexp);
        bit got = 1'b0;
        exp_q.push_back(ev(port_b ? K_BGNT : K_AGNT, we, addr, we ? wd : 16'h0));
        if (!we) exp_q.push_back(ev(port_b ? K_BRV : K_ARV, 1'b0, '0, rexp));
        if (port_b) begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = we ? wd : 16'h0;
        end else begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = we ? wd : 16'h0;
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (port_b ? b_gnt : a_gnt) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL op_timeout: port_b=%0b got no gnt within 40 cycles", port_b);
        end
        @(posedge clk);
        #1;
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    // Holds both ports requesting reads until n grants were observed.
    task automatic both_reads(input logic [ADDR_W-1:0] aa, input logic [ADDR_W-1:0] ba, input int n);
        int seen = 0;
        a_req = 1'b1; a_we = 1'b0; a_addr = aa; a_wdata = '0;
        b_req = 1'b1; b_we = 1'b0; b_addr = ba; b_wdata = '0;
        for (int i = 0; i < 60 && seen < n; i++) begin
            @(negedge clk);
            if (a_gnt || b_gnt) seen++;
        end
        checks++;
        if (seen != n) begin
            errors++;
            $display("FAIL both_reads_timeout: grants=%0d required=%0d", seen, n);
        end
        @(posedge clk);
        #1;
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        for (int i = 0; i < 8; i++) tb_mem[i] = 16'h1000 + 16'(i);

        // Reset and reset-state checks
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_a_gnt",    {15'b0, a_gnt},    16'h0);
        chk("rst_b_gnt",    {15'b0, b_gnt},    16'h0);
        chk("rst_a_rvalid", {15'b0, a_rvalid}, 16'h0);
        chk("rst_b_rvalid", {15'b0, b_rvalid}, 16'h0);
        chk("rst_mem_load", {15'b0, mem_load}, 16'h0);
        chk("rst_clr_busy", {15'b0, clr_busy}, 16'h0);
        chk("rst_a_rdata",  a_rdata,           16'h0);
        chk("rst_b_rdata",  b_rdata,           16'h0);
        chk("rst_mem_addr", {13'b0, mem_addr}, 16'h0);
        chk("rst_mem_wdata", mem_wdata,        16'h0);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Round-robin from reset: A, B, A, B
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(ev(K_AGNT, 1'b0, 3'd1, 16'h0));
            exp_q.push_back(ev(K_ARV,  1'b0, 3'd0, 16'h1001));
            exp_q.push_back(ev(K_BGNT, 1'b0, 3'd2, 16'h0));
            exp_q.push_back(ev(K_BRV,  1'b0, 3'd0, 16'h1002));
        end
        both_reads(3'd1, 3'd2, 4);
        idle(2);

        // Write then read on port A
        op(1'b0, 1'b1, 3'd5, 16'h1234, 16'h0);
        op(1'b0, 1'b0, 3'd5, 16'h0,    16'h1234);

        // Port B write/read; A's read data must stay intact
        op(1'b1, 1'b1, 3'd6, 16'hBEEF, 16'h0);
        op(1'b1, 1'b0, 3'd6, 16'h0,    16'hBEEF);
        idle(2);
        chk("a_rdata_held", a_rdata, 16'h1234);
        chk("b_rdata_beef", b_rdata, 16'hBEEF);

        // Clear together with an A read: clear first, then the read returns 0
        for (int i = 0; i < 8; i++) exp_q.push_back(ev(K_CLR, 1'b1, 3'(i), 16'h0));
        exp_q.push_back(ev(K_AGNT, 1'b0, 3'd5, 16'h0));
        exp_q.push_back(ev(K_ARV,  1'b0, 3'd0, 16'h0));
        clr_req = 1'b1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 3'd5; a_wdata = '0;
        @(negedge clk);
        n = 1;
        @(posedge clk);
        #1 clr_req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (a_gnt) break;
        end
        chk("clear_then_gnt_cycles", 16'(n), 16'd11);
        @(posedge clk);
        #1 a_req = 1'b0;
        idle(2);
        chk("a_rdata_after_clear", a_rdata, 16'h0);

        // Reset in the 4th clear cycle aborts the clear
        for (int i = 0; i < 4; i++) exp_q.push_back(ev(K_CLR, 1'b1, 3'(i), 16'h0));
        clr_req = 1'b1;
        @(posedge clk);
        #1 clr_req = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_clr_busy", {15'b0, clr_busy}, 16'h0);
        chk("abort_mem_load", {15'b0, mem_load}, 16'h0);
        @(posedge clk);
        #1;
        // Tie right after reset: A wins first
        exp_q.push_back(ev(K_AGNT, 1'b0, 3'd5, 16'h0));
        exp_q.push_back(ev(K_ARV,  1'b0, 3'd0, 16'h0));
        exp_q.push_back(ev(K_BGNT, 1'b0, 3'd2, 16'h0));
        exp_q.push_back(ev(K_BRV,  1'b0, 3'd0, 16'h0));
        both_reads(3'd5, 3'd2, 2);

        // Drain
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected events never seen, required 0", exp_q.size());
        end
        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
